rx_acq_sequencer: RTL

//  Sequences HFSWR receive sweeps on the ADC clock. Sits after the I/Q FIR outputs
//  ({I,Q} 32-bit stream). On each transmitter sweep trigger it skips a range-gate

---
 rtl/rx_acq_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rx_acq_sequencer.sv
// HFSWR receive sweep sequencer: per trig, skip a range-gate delay, capture a
// fixed window of I/Q samples into a FWFT FIFO and stream it out ready/valid.
module rx_acq_sequencer #(
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             trig,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_sweeps,
    input  logic [31:0]      cfg_phase,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_last,
    output logic [31:0]      phase_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sweep_cnt,
    output logic             overflow,
    output logic             trig_miss
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DRAIN} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] delay_q, len_q, sweeps_q;
    logic [CNT_W-1:0] cnt, cnt_n, sweep_n;
    logic             ovf_n, miss_n, done_n;
    logic             wr_req, wr_last, latch, flush;
    logic             rd, wr_en, full, empty;
    logic [PW-1:0]    wptr, rptr, wptr_n, rptr_n;
    logic [32:0]      mem [DEPTH];
    logic [32:0]      head_n;

    // Extra pointer bit distinguishes full from empty
    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign rd    = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sweep_n = sweep_cnt;
        ovf_n   = overflow;
        miss_n  = trig_miss;
        done_n  = 1'b0;
        wr_req  = 1'b0;
        wr_last = 1'b0;
        latch   = 1'b0;
        flush   = 1'b0;
        case (state)
            IDLE: begin
                if (start && (cfg_len != '0) && (cfg_sweeps != '0)) begin
                    latch   = 1'b1;
                    sweep_n = '0;
                    ovf_n   = 1'b0;
                    miss_n  = 1'b0;
                    state_n = ARMED;
                end
            end
            ARMED: begin
                if (trig) begin
                    cnt_n   = '0;
                    state_n = (delay_q == '0) ? CAPTURE : DELAY;
                end
            end
            DELAY: begin
                if (trig) miss_n = 1'b1;
                // The delay-th valid sample is consumed by the transition itself
                if (s_valid) begin
                    if (cnt == delay_q - CNT_W'(1)) begin
                        cnt_n   = '0;
                        state_n = CAPTURE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            CAPTURE: begin
                if (trig) miss_n = 1'b1;
                if (s_valid) begin
                    wr_req  = 1'b1;
                    wr_last = (cnt == len_q - CNT_W'(1));
                    if (wr_last) begin
                        cnt_n   = '0;
                        sweep_n = sweep_cnt + CNT_W'(1);
                        state_n = (sweep_n == sweeps_q) ? DRAIN : ARMED;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (empty) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Window counter keeps running even when the sample is dropped
        if (wr_req && full && !rd) ovf_n = 1'b1;
        if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            sweep_n = sweep_cnt;
            ovf_n   = overflow;
            miss_n  = trig_miss;
            done_n  = 1'b0;
            wr_req  = 1'b0;
            latch   = 1'b0;
            flush   = 1'b1;
        end
    end

    // FIFO pointer update and head prefetch (bypass when writing into the head slot)
    always_comb begin
        wr_en  = wr_req && (!full || rd);
        wptr_n = flush ? '0 : wptr + PW'(wr_en);
        rptr_n = flush ? '0 : rptr + PW'(rd);
        head_n = (wr_en && (wptr == rptr_n)) ? {wr_last, s_data}
                                             : mem[rptr_n[FIFO_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[FIFO_AW-1:0]] <= {wr_last, s_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_q   <= '0;
            len_q     <= '0;
            sweeps_q  <= '0;
            phase_o   <= '0;
            cnt       <= '0;
            sweep_cnt <= '0;
            overflow  <= 1'b0;
            trig_miss <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
        end else begin
            if (latch) begin
                delay_q  <= cfg_delay;
                len_q    <= cfg_len;
                sweeps_q <= cfg_sweeps;
                phase_o  <= cfg_phase;
            end
            cnt       <= cnt_n;
            sweep_cnt <= sweep_n;
            overflow  <= ovf_n;
            trig_miss <= miss_n;
            done      <= done_n;
            busy      <= (state_n != IDLE);
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            m_valid   <= (wptr_n != rptr_n);
            if (wptr_n != rptr_n) begin
                m_data <= head_n[31:0];
                m_last <= head_n[32];
            end
        end
    end

endmodule
